inc_dec_n: RTL

INC_DEC_N -- requirements
Module: inc_dec_n

---
 rtl/inc_dec_n.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inc_dec_n.sv
// Streaming incrementer/decrementer: adds or subtracts a zero-extended step
// from an unsigned operand. Results queue in a 2-entry in-order output buffer
// with valid/ready handshakes on both sides.
// Optional feature macro: INC_DEC_SAT_EN. When it is defined, i_Sat=1 clamps
// overflow to all-ones and underflow to zero.
`timescale 1ns/1ps

module inc_dec_n #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 4
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Valid,
  output logic              o_Ready,
  input  logic [WIDTH-1:0]  i_Binary_Num,
  input  logic [STEP_W-1:0] i_Step,
  input  logic              i_Dec,
  input  logic              i_Sat,
  output logic              o_Valid,
  input  logic              i_Ready,
  output logic [WIDTH-1:0]  o_Binary_Num,
  output logic              o_Carry
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_head_num;
  logic             r_head_carry;
  logic [WIDTH-1:0] r_tail_num;
  logic             r_tail_carry;

  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_accept;
  logic             w_pop;

  // Zero-extend the step to one bit wider than the operand.
  always_comb begin
    w_step_ext             = '0;
    w_step_ext[STEP_W-1:0] = i_Step;
  end

  // The extra top bit holds the carry (add) or borrow (subtract).
  assign w_sum  = {1'b0, i_Binary_Num} + w_step_ext;
  assign w_diff = {1'b0, i_Binary_Num} - w_step_ext;

  // Select the wrapped result and the out-of-range flag, then apply optional clamping.
  always_comb begin
    w_carry = i_Dec ? w_diff[WIDTH] : w_sum[WIDTH];
    w_res   = i_Dec ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
`ifdef INC_DEC_SAT_EN
    if (i_Sat && w_carry) begin
      w_res = i_Dec ? '0 : '1;
    end
`endif
  end

`ifndef INC_DEC_SAT_EN
  logic w_unused_sat;
  assign w_unused_sat = i_Sat;
`endif

  assign w_accept = i_Valid & r_ready;
  assign w_pop    = r_valid & i_Ready;

  // Buffer FSM. Ready and valid are registered copies of the state decode.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= StEmpty;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_head_num   <= '0;
      r_head_carry <= 1'b0;
      r_tail_num   <= '0;
      r_tail_carry <= 1'b0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_head_num   <= w_res;
            r_head_carry <= w_carry;
            r_valid      <= 1'b1;
            r_state      <= StOne;
          end
        end
        StOne: begin
          if (w_accept && w_pop) begin
            // The head leaves and the new result takes its place.
            r_head_num   <= w_res;
            r_head_carry <= w_carry;
          end else if (w_accept) begin
            r_tail_num   <= w_res;
            r_tail_carry <= w_carry;
            r_ready      <= 1'b0;
            r_state      <= StFull;
          end else if (w_pop) begin
            r_valid      <= 1'b0;
            r_state      <= StEmpty;
          end
        end
        StFull: begin
          // Ready is low here, so no accept can coincide with this pop.
          if (w_pop) begin
            r_head_num   <= r_tail_num;
            r_head_carry <= r_tail_carry;
            r_ready      <= 1'b1;
            r_state      <= StOne;
          end
        end
        default: begin
          r_state <= StEmpty;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_Ready      = r_ready;
  assign o_Valid      = r_valid;
  assign o_Binary_Num = r_head_num;
  assign o_Carry      = r_head_carry;

endmodule
